// File: rtl/opb_master_pkg.sv
// opb_master_pkg
// Shared types and helpers for the OPB command master.
//   state_e  : master FSM states (also visible on the debug state output)
//   status_e : response status codes returned on rsp_status
//   to_opb32 / to_opb4 / from_opb32 : move between the local [31:0]
//     numbering (bit 31 = MSB) and the OPB [0:N] numbering (bit 0 = MSB).
//     The numeric value is unchanged; only the bit index order flips.
package opb_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_XFER    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_ERRACK  = 2'd1,
        STAT_TIMEOUT = 2'd2,
        STAT_RETRY   = 2'd3
    } status_e;

    // Local bit i (LSB = 0) lands on OPB bit 31-i (OPB bit 0 = MSB).
    function automatic logic [0:31] to_opb32(input logic [31:0] v);
        logic [0:31] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    function automatic logic [0:3] to_opb4(input logic [3:0] v);
        logic [0:3] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = v[3 - i];
        end
        return r;
    endfunction

    function automatic logic [31:0] from_opb32(input logic [0:31] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_master_cmd_wdog.sv
// opb_master_wdog
// Transfer watchdog: loadable down-counter with a pause input.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (clears the count)
//   load_i    : reload to C_WDOG_CYCLES-1 (asserted on the edge that enters XFER)
//   active_i  : high while the master is in XFER; only then does it count
//   pause_i   : hold the count this cycle (OPB_toutSup)
//   expired_o : high during the C_WDOG_CYCLES-th counted XFER cycle
// Only instantiated when OPB_MASTER_WATCHDOG_EN is defined.
module opb_master_wdog #(
    parameter int unsigned C_WDOG_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic active_i,
    input  logic pause_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(C_WDOG_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(C_WDOG_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (active_i && !pause_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count reaches zero at the start of the last allowed cycle; a paused
    // cycle does not count, so it cannot expire either.
    assign expired_o = active_i && !pause_i && (cnt_q == '0);

endmodule

// File: rtl/opb_master_cmd.sv
// opb_master_cmd
// OPB bus master: turns a valid/ready command stream into single-beat OPB
// read/write transfers and returns one response per command.
//
// Handshakes: a transfer happens on a rising OPB_Clk edge where valid and
// ready are both high; once raised, valid and the payload stay stable until
// that edge.
//
// Ports:
//   OPB_Clk, OPB_Rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake (ready only in IDLE)
//   cmd_rnw, cmd_addr, cmd_be, cmd_wdata : command payload
//   rsp_valid/rsp_ready           : response handshake
//   rsp_status, rsp_rdata         : 0 OK, 1 ERRACK, 2 TIMEOUT, 3 RETRY_EXHAUSTED
//   M_request, M_select, M_RNW, M_busLock, M_seqAddr : OPB master controls
//   M_ABus[0:31], M_BE[0:3], M_DBus[0:31]            : OPB master buses
//   OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_toutSup
//   OPB_DBus[0:31]                : arbiter / slave responses and read data
//   dbg_state_o                   : current FSM state (opb_master_pkg::state_e)
//
// Build option: OPB_MASTER_WATCHDOG_EN compiles in the local XFER watchdog
// (limit C_WDOG_CYCLES). Without it only OPB_timeout ends a hung transfer.
module opb_master_cmd
    import opb_master_pkg::*;
#(
    parameter int unsigned C_MAX_RETRY   = 3,
    parameter int unsigned C_WDOG_CYCLES = 255
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    output logic        M_request,
    output logic        M_select,
    output logic        M_RNW,
    output logic        M_busLock,
    output logic        M_seqAddr,
    output logic [0:31] M_ABus,
    output logic [0:3]  M_BE,
    output logic [0:31] M_DBus,
    input  logic        OPB_MGrant,
    input  logic        OPB_xferAck,
    input  logic        OPB_errAck,
    input  logic        OPB_retry,
    input  logic        OPB_timeout,
    input  logic        OPB_toutSup,
    input  logic [0:31] OPB_DBus,
    output logic [2:0]  dbg_state_o
);

    localparam int unsigned RW = (C_MAX_RETRY == 0) ? 1 : $clog2(C_MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY = RW'(C_MAX_RETRY);

    state_e        state_q, state_d;
    logic          rnw_q, rnw_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [RW-1:0] retry_q, retry_d;
    status_e       status_q, status_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          wdog_expired;

`ifdef OPB_MASTER_WATCHDOG_EN
    opb_master_wdog #(
        .C_WDOG_CYCLES(C_WDOG_CYCLES)
    ) u_wdog (
        .clk_i    (OPB_Clk),
        .rst_i    (OPB_Rst),
        .load_i   ((state_q == ST_REQ) && OPB_MGrant),
        .active_i (state_q == ST_XFER),
        .pause_i  (OPB_toutSup),
        .expired_o(wdog_expired)
    );
`else
    logic unused_wdog;
    assign wdog_expired = 1'b0;
    assign unused_wdog  = OPB_toutSup ^ (C_WDOG_CYCLES == 0);
`endif

    // State and command/response registers.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q  <= ST_IDLE;
            rnw_q    <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            retry_q  <= '0;
            status_q <= STAT_OK;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            retry_q  <= retry_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state and register updates.
    always_comb begin
        state_d  = state_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        retry_d  = retry_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rnw_d    = cmd_rnw;
                    addr_d   = cmd_addr;
                    be_d     = cmd_be;
                    wdata_d  = cmd_wdata;
                    retry_d  = '0;
                    status_d = STAT_OK;
                    rdata_d  = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (OPB_MGrant) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Ack beats retry beats timeout when several arrive together.
                if (OPB_xferAck) begin
                    if (OPB_errAck) begin
                        status_d = STAT_ERRACK;
                        rdata_d  = '0;
                    end else begin
                        status_d = STAT_OK;
                        rdata_d  = rnw_q ? from_opb32(OPB_DBus) : '0;
                    end
                    state_d = ST_RESP;
                end else if (OPB_retry) begin
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_BACKOFF;
                    end else begin
                        status_d = STAT_RETRY;
                        rdata_d  = '0;
                        state_d  = ST_RESP;
                    end
                end else if (OPB_timeout || wdog_expired) begin
                    status_d = STAT_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = ST_RESP;
                end
            end
            ST_BACKOFF: begin
                state_d = ST_REQ;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from the state only; buses are zero unless selected.
    always_comb begin
        cmd_ready  = 1'b0;
        M_request  = 1'b0;
        M_select   = 1'b0;
        M_RNW      = 1'b0;
        M_ABus     = '0;
        M_BE       = '0;
        M_DBus     = '0;
        rsp_valid  = 1'b0;
        rsp_status = 2'b00;
        rsp_rdata  = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_REQ: begin
                M_request = 1'b1;
            end
            ST_XFER: begin
                M_select = 1'b1;
                M_RNW    = rnw_q;
                M_ABus   = to_opb32(addr_q);
                M_BE     = to_opb4(be_q);
                M_DBus   = rnw_q ? '0 : to_opb32(wdata_q);
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                rsp_status = status_q;
                rsp_rdata  = rdata_q;
            end
            default: begin
            end
        endcase
    end

    assign M_busLock   = 1'b0;
    assign M_seqAddr   = 1'b0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_opb_master_cmd.sv
module tb_opb_master_cmd;
    import opb_master_pkg::*;

    localparam int MAXR = 3;
    localparam int WDOG = 16;

    localparam int K_NONE  = 0;
    localparam int K_ACK   = 1;
    localparam int K_ERR   = 2;
    localparam int K_RETRY = 3;
    localparam int K_TOUT  = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        M_request, M_select, M_RNW, M_busLock, M_seqAddr;
    logic [0:31] M_ABus, M_DBus, OPB_DBus;
    logic [0:3]  M_BE;
    logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_toutSup;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    opb_master_cmd #(
        .C_MAX_RETRY  (MAXR),
        .C_WDOG_CYCLES(WDOG)
    ) dut (
        .OPB_Clk    (clk),
        .OPB_Rst    (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rnw    (cmd_rnw),
        .cmd_addr   (cmd_addr),
        .cmd_be     (cmd_be),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_rdata  (rsp_rdata),
        .M_request  (M_request),
        .M_select   (M_select),
        .M_RNW      (M_RNW),
        .M_busLock  (M_busLock),
        .M_seqAddr  (M_seqAddr),
        .M_ABus     (M_ABus),
        .M_BE       (M_BE),
        .M_DBus     (M_DBus),
        .OPB_MGrant (OPB_MGrant),
        .OPB_xferAck(OPB_xferAck),
        .OPB_errAck (OPB_errAck),
        .OPB_retry  (OPB_retry),
        .OPB_timeout(OPB_timeout),
        .OPB_toutSup(OPB_toutSup),
        .OPB_DBus   (OPB_DBus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [33:0] exp_q[$];          // {status, rdata}
    logic        cur_rnw;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;

    // Request rising-edge counter (sampled mid-cycle).
    int   req_rises = 0;
    logic req_prev  = 1'b0;
    always @(negedge clk) begin
        if (M_request && !req_prev) req_rises++;
        req_prev = M_request;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE.
    task automatic send_cmd(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic push,
                            input logic [1:0] exp_status, input logic [31:0] exp_rdata);
        check("cmd_ready_idle", cmd_ready, 1);
        cur_rnw = rnw; cur_addr = addr; cur_be = be; cur_wdata = wdata;
        cmd_valid = 1; cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata;
        if (push) exp_q.push_back({exp_status, exp_rdata});
        tick();
        cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_be = 0; cmd_wdata = 0;
        check("req_after_accept", M_request, 1);
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    // Wait d cycles in REQ (optionally with a stray ack), then grant once.
    task automatic grant(input int d, input logic stray_ack);
        int bad = 0;
        repeat (d) begin
            if (!M_request || M_select) bad++;
            OPB_xferAck = stray_ack;
            tick();
            OPB_xferAck = 0;
        end
        OPB_MGrant = 1;
        tick();
        OPB_MGrant = 0;
        check("req_wait", bad, 0);
    endtask

    // Run the XFER phase; responds with 'kind' in select cycle ack_at.
    task automatic xfer(input int ack_at, input int kind, input logic [31:0] dbus,
                        input int tsup_n, output int sel);
        int bad = 0;
        sel = 0;
        while (M_select && sel < 300) begin
            sel++;
            if (M_ABus !== cur_addr || M_BE !== cur_be || M_RNW !== cur_rnw ||
                M_DBus !== (cur_rnw ? 32'h0 : cur_wdata) || M_request !== 1'b0) bad++;
            OPB_toutSup = (sel >= 2) && (sel < 2 + tsup_n);
            OPB_DBus    = $urandom;
            if (sel == ack_at) begin
                case (kind)
                    K_ACK:   begin OPB_xferAck = 1; OPB_DBus = dbus; end
                    K_ERR:   begin OPB_xferAck = 1; OPB_errAck = 1; OPB_DBus = dbus; end
                    K_RETRY: OPB_retry = 1;
                    K_TOUT:  OPB_timeout = 1;
                    default: ;
                endcase
            end
            tick();
            OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0; OPB_timeout = 0;
            OPB_toutSup = 0; OPB_DBus = 0;
        end
        check("bus_fields", bad, 0);
    endtask

    task automatic get_rsp(input int hold);
        logic [33:0] first, exp;
        int bad = 0;
        int w = 0;
        while (!rsp_valid && w < 50) begin tick(); w++; end
        check("rsp_immediate", w, 0);
        check("rsp_valid", rsp_valid, 1);
        check("ctrl_idle_in_rsp", {M_select, M_request, M_RNW, M_BE}, 0);
        check("bus_idle_in_rsp", {M_ABus, M_DBus}, 0);
        first = {rsp_status, rsp_rdata};
        repeat (hold) begin
            tick();
            if (!rsp_valid || {rsp_status, rsp_rdata} !== first || cmd_ready) bad++;
        end
        check("rsp_hold", bad, 0);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("rsp_status_data", first, exp);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("rsp_done", rsp_valid, 0);
        check("ready_again", cmd_ready, 1);
    endtask

    task automatic retry_round();
        int s;
        xfer(1, K_RETRY, 0, 0, s);
        check("retry_sel_len", s, 1);
        check("backoff_idle", {M_request, M_select}, 0);
        tick();
        check("rereq", M_request, 1);
        grant(0, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int sel;
        int r0;
        logic [33:0] first;
        int bad;

        rst = 1; cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_be = 0; cmd_wdata = 0;
        rsp_ready = 0; OPB_MGrant = 0; OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0;
        OPB_timeout = 0; OPB_toutSup = 0; OPB_DBus = 0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ctrl", {M_request, M_select, M_RNW, M_busLock, M_seqAddr, rsp_valid, M_BE}, 0);
        check("rst_bus", {M_ABus, M_DBus}, 0);
        check("rst_rsp", {rsp_status, rsp_rdata}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 0;
        tick();

        // Write; stray ack during REQ must be ignored.
        send_cmd(0, 32'h0001_0008, 4'hF, 32'h1234_ABCD, 1, STAT_OK, 32'h0);
        grant(2, 1);
        xfer(3, K_ACK, 32'h0, 0, sel);
        check("wr_sel_len", sel, 3);
        get_rsp(0);

        // Read
        send_cmd(1, 32'h0001_0010, 4'h1, 32'hFFFF_FFFF, 1, STAT_OK, 32'hDEAD_BEEF);
        grant(1, 0);
        xfer(2, K_ACK, 32'hDEAD_BEEF, 0, sel);
        check("rd_sel_len", sel, 2);
        get_rsp(0);

        // Minimum latency: grant and ack in their first cycles
        send_cmd(1, 32'h8000_0004, 4'hC, 32'h0, 1, STAT_OK, 32'h0F1E_2D3C);
        grant(0, 0);
        xfer(1, K_ACK, 32'h0F1E_2D3C, 0, sel);
        check("minlat_sel_len", sel, 1);
        get_rsp(0);

        // Two retries, then ack
        r0 = req_rises;
        send_cmd(1, 32'h0000_0020, 4'hF, 32'h0, 1, STAT_OK, 32'hCAFE_0001);
        grant(1, 0);
        retry_round();
        retry_round();
        xfer(2, K_ACK, 32'hCAFE_0001, 0, sel);
        check("retry2_sel_len", sel, 2);
        get_rsp(0);
        check("retry2_req_rises", req_rises - r0, 3);

        // Four retries: exhausted, no fourth re-request
        r0 = req_rises;
        send_cmd(0, 32'h0000_0024, 4'h6, 32'h7777_0000, 1, STAT_RETRY, 32'h0);
        grant(0, 0);
        retry_round();
        retry_round();
        retry_round();
        xfer(1, K_RETRY, 32'h0, 0, sel);
        check("retry4_sel_len", sel, 1);
        get_rsp(0);
        check("retry4_req_rises", req_rises - r0, 4);

        // Error acknowledge on a read
        send_cmd(1, 32'h0000_0030, 4'h3, 32'h0, 1, STAT_ERRACK, 32'h0);
        grant(0, 0);
        xfer(1, K_ERR, 32'h55AA_55AA, 0, sel);
        check("errack_sel_len", sel, 1);
        get_rsp(0);

        // Reset mid-XFER discards the command
        send_cmd(0, 32'h0000_0034, 4'hF, 32'h0BAD_F00D, 0, STAT_OK, 32'h0);
        grant(0, 0);
        check("pre_rst_sel", M_select, 1);
        tick();
        rst = 1;
        tick();
        check("midrst_ctrl", {M_select, M_request, rsp_valid}, 0);
        check("midrst_ready", cmd_ready, 1);
        rst = 0;
        repeat (2) tick();
        check("midrst_no_rsp", rsp_valid, 0);

        // Arbiter timeout pulse
        send_cmd(1, 32'h0000_0040, 4'hF, 32'h0, 1, STAT_TIMEOUT, 32'h0);
        grant(0, 0);
        xfer(5, K_TOUT, 32'h0, 0, sel);
        check("tout_sel_len", sel, 5);
        get_rsp(0);

`ifdef OPB_MASTER_WATCHDOG_EN
        send_cmd(0, 32'h0000_0044, 4'hF, 32'h1111_2222, 1, STAT_TIMEOUT, 32'h0);
        grant(0, 0);
        xfer(0, K_NONE, 32'h0, 0, sel);
        check("wdog_sel_len", sel, WDOG);
        get_rsp(0);

        send_cmd(1, 32'h0000_0048, 4'hF, 32'h0, 1, STAT_TIMEOUT, 32'h0);
        grant(0, 0);
        xfer(0, K_NONE, 32'h0, 5, sel);
        check("wdog_tsup_sel_len", sel, WDOG + 5);
        get_rsp(0);
`else
        send_cmd(0, 32'h0000_0044, 4'hF, 32'h1111_2222, 1, STAT_TIMEOUT, 32'h0);
        grant(0, 0);
        xfer(40, K_TOUT, 32'h0, 0, sel);
        check("nowdog_sel_len", sel, 40);
        get_rsp(0);
`endif

        // Back-pressure with a pending command
        send_cmd(0, 32'h0000_0050, 4'hF, 32'hA5A5_0F0F, 1, STAT_OK, 32'h0);
        grant(0, 0);
        xfer(1, K_ACK, 32'h0, 0, sel);
        check("bp_rsp_valid", rsp_valid, 1);
        cmd_valid = 1; cmd_rnw = 1; cmd_addr = 32'h0000_0054; cmd_be = 4'hF; cmd_wdata = 0;
        first = {rsp_status, rsp_rdata};
        bad = 0;
        repeat (10) begin
            tick();
            if (!rsp_valid || {rsp_status, rsp_rdata} !== first || cmd_ready || M_request) bad++;
        end
        check("bp_hold", bad, 0);
        check("bp_data", first, (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("bp_not_taken", M_request, 0);
        check("bp_ready_idle", cmd_ready, 1);
        cur_rnw = 1; cur_addr = 32'h0000_0054; cur_be = 4'hF; cur_wdata = 0;
        exp_q.push_back({STAT_OK, 32'h1357_9BDF});
        tick();
        cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_be = 0;
        check("bp_accept", M_request, 1);
        grant(0, 0);
        xfer(1, K_ACK, 32'h1357_9BDF, 0, sel);
        check("bp2_sel_len", sel, 1);
        get_rsp(0);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/opb_master_cmd.md
# opb_master_cmd

OPB bus master that turns a simple valid/ready command stream into single-beat OPB read/write transactions and returns one response per command. It is the initiating end of the OPB slave attachments in our pcores. Typical use: a control engine or debug bridge programming peripheral registers such as the XAUI equalisation and drive registers, and reading back status, over the shared OPB. It handles arbitration, retry back-off, error acknowledge and transfer timeout.

## Interface
Reset is synchronous and active-high; all logic runs on one clock, `OPB_Clk`, with reset `OPB_Rst`.

Parameters:
- `C_MAX_RETRY`, default 3: number of `OPB_retry` responses tolerated per command before giving up.
- `C_WDOG_CYCLES`, default 255: local watchdog limit in `XFER` cycles. Must be at least 2. Used only with `OPB_MASTER_WATCHDOG_EN`.

Ports:
- `OPB_Clk` in 1: clock.
- `OPB_Rst` in 1: synchronous active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_rnw` in 1: 1 = read, 0 = write.
- `cmd_addr` in 32: byte address.
- `cmd_be` in 4: byte enables; `cmd_be[3]` is the most significant lane.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_status` out 2: 0 OK, 1 ERRACK, 2 TIMEOUT, 3 RETRY_EXHAUSTED.
- `rsp_rdata` out 32: read data.
- `M_request` out 1, `M_select` out 1, `M_RNW` out 1, `M_busLock` out 1, `M_seqAddr` out 1: OPB master controls.
- `M_ABus` out [0:31], `M_BE` out [0:3], `M_DBus` out [0:31]: OPB master address, byte-enable and data buses.
- `OPB_MGrant` in 1, `OPB_xferAck` in 1, `OPB_errAck` in 1, `OPB_retry` in 1, `OPB_timeout` in 1, `OPB_toutSup` in 1: OPB arbiter and slave responses.
- `OPB_DBus` in [0:31]: OPB read data.

## Operation
Bus mapping:
- `M_ABus[0:31]` = `cmd_addr[31:0]`, MSB first. `M_DBus` and `OPB_DBus` map the same way.
- `M_BE[0:3]` = `cmd_be[3:0]`.
- `M_busLock` and `M_seqAddr` are tied to 0.

Bus-idle rule:
- `M_ABus`, `M_BE`, `M_RNW` and `M_DBus` are all zero whenever `M_select` is 0.
- `M_DBus` is also zero during reads.

States (FSM):
- **IDLE**: `cmd_ready`=1. When `cmd_valid` is high, latch all command fields, clear the retry counter, and go to REQ.
- **REQ**: `M_request`=1. When `OPB_MGrant` is sampled high, go to XFER.
- **XFER**: `M_select`=1, `M_request`=0, buses driven. The first matching condition below wins (priority top to bottom):
  - `OPB_xferAck`: capture `OPB_DBus` if reading; status = ERRACK if `OPB_errAck` is also high, else OK; go to RESP.
  - `OPB_retry`: if retry count < `C_MAX_RETRY`, increment it and go to BACKOFF; otherwise status = RETRY_EXHAUSTED and go to RESP.
  - `OPB_timeout`, or watchdog expiry: status = TIMEOUT; go to RESP.
- **BACKOFF**: one cycle with request and select both low, then go to REQ.
- **RESP**: `rsp_valid`=1, outputs held stable. When `rsp_ready` is high, go to IDLE.

Additional rules:
- `rsp_rdata` is 0 for writes and for any status other than OK.
- Only one command is outstanding at a time. `cmd_ready` is 1 only in IDLE.

Reset values:
- Every output is 0 except `cmd_ready`, which is 1.
- State is IDLE; retry counter and watchdog are cleared.
- Reset asserted in any state, including mid-XFER, drops `M_select`, `M_request` and `rsp_valid` at that edge and discards the in-flight command with no response.

## Timing
- Command accepted at edge N. `M_request` is high from cycle N+1.
- Grant sampled high at edge G. `M_select` and the buses are valid from cycle G+1.
- Acknowledge sampled at edge A. `M_select` is low and `rsp_valid` is high from cycle A+1.
- Minimum command-to-response latency: 3 cycles (grant and ack each in their first cycle).
- `M_select` is high for exactly (A − G) cycles.
- `OPB_xferAck` is ignored outside XFER.
- The watchdog counts XFER cycles, holds its count while `OPB_toutSup`=1, and clears on every XFER entry.
- Watchdog expiry occurs on the `C_WDOG_CYCLES`-th XFER cycle; `M_select` falls on the following edge.

## Configuration
- `OPB_MASTER_WATCHDOG_EN` defined: the local watchdog is compiled in. It produces TIMEOUT even when no arbiter timeout is present.
- Undefined: the watchdog logic is absent. Only `OPB_timeout` ends a hung transfer, and `C_WDOG_CYCLES` is unused.

## Structure
- Package `opb_master_pkg` holds:
  - the state enum (IDLE, REQ, XFER, BACKOFF, RESP);
  - the status codes STAT_OK, STAT_ERRACK, STAT_TIMEOUT, STAT_RETRY;
  - an OPB bit-reversal helper function.
- One natural sub-module, `opb_master_wdog`: loadable down-counter with a pause input (`OPB_toutSup`) and an expiry flag. It is instantiated only under `OPB_MASTER_WATCHDOG_EN`.

## Test plan
- **Write:** addr 0x0001_0008, data 0x1234ABCD, be 0xF; grant 2 cycles after request; ack 3 cycles into XFER -> `M_ABus`=0x00010008 and `M_DBus`=0x1234ABCD while selected; `M_select` high exactly 3 cycles; status 0.
- **Read:** addr 0x0001_0010, be 0x1, ack with `OPB_DBus`=0xDEADBEEF -> `M_BE`=0001, `M_DBus`=0 throughout, `rsp_rdata`=0xDEADBEEF, status 0.
- **Retry:** `C_MAX_RETRY`=3.
  - Two retries, then ack -> `M_request` rises 3 times with one idle cycle before each re-request; status 0.
  - Four retries -> status 3 with no fourth re-request.
- **Error and reset:**
  - `OPB_errAck` together with `OPB_xferAck` on a read -> status 1, `rsp_rdata`=0.
  - `OPB_Rst` mid-XFER -> next cycle `M_select`=0, `rsp_valid`=0, `cmd_ready`=1.
- **Timeout:**
  - With macro, `C_WDOG_CYCLES`=16, no ack -> `M_select` drops after 16 cycles, status 2.
  - With `OPB_toutSup` held for 5 of those cycles -> drop after 21 cycles.
  - Without macro -> only an `OPB_timeout` pulse ends the transfer.
- **Back-pressure:** hold `rsp_ready`=0 for 10 cycles -> response held stable, `cmd_ready`=0, a pending `cmd_valid` is not accepted until the cycle after the response handshake.
